arrow_plot_arbiter: RTL and testbench
=====================================

ARROW_PLOT_ARBITER -- requirements
Module: arrow_plot_arbiter

Interface
REQ-001 Parameter WDOG_LIMIT, default 23'd4000000: DRAW-state cycle limit before a forced release.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset_n  input  1  reset, synchronous, active-low; clock clk.
REQ-004 req  input  4  draw request per drawer; bit i = drawer i.
REQ-005 drw_x  input  32  drawer x coordinates; drawer i on bits [8i+7:8i].
REQ-006 drw_y  input  28  drawer y coordinates; drawer i on bits [7i+6:7i].
REQ-007 drw_colour  input  12  drawer colours; drawer i on bits [3i+2:3i].
REQ-008 drw_plot  input  4  drawer pixel-write strobes.
REQ-009 drw_done  input  4  drawer shape-complete flags.
REQ-010 grant  output  4  one-hot grant; all zero when no drawer is granted.
REQ-011 dp_reset_n  output  4  per-drawer datapath reset, active-low; bit i high only while drawer i is granted.
REQ-012 vga_x  output  8, vga_y  output  7, vga_colour  output  3, vga_plot  output  1: muxed VGA adapter write port.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 timeout  output  1  one-cycle pulse on a watchdog release.

Function
REQ-015 FSM states: IDLE, GRANT, DRAW, RELEASE; encoding is free.
REQ-016 IDLE: if req != 0, select a winner and go to GRANT; otherwise stay in IDLE.
REQ-017 Selection: round-robin; search order starts at last_winner+1 mod 4 and wraps; the first set req bit wins.
REQ-018 GRANT: lasts one cycle; grant and dp_reset_n bits for the winner go high; next state is DRAW.
REQ-019 DRAW: hold the grant until the winner's drw_done = 1, then go to RELEASE.
REQ-020 In DRAW, deassertion of the winner's req is ignored; the grant holds.
REQ-021 drw_done and drw_plot from non-granted drawers are ignored in all states; the winner's drw_done is ignored in GRANT.
REQ-022 RELEASE: lasts one cycle; grant = 0, all dp_reset_n = 0, last_winner updated; next state is IDLE.
REQ-023 The RELEASE->IDLE->GRANT path means back-to-back grants are separated by at least 2 cycles with grant = 0.
REQ-024 vga_x, vga_y, vga_colour, vga_plot are registered; each equals the winner's inputs delayed by exactly 1 cycle.
REQ-025 vga_plot = 1 only if the winner's drw_plot was 1 while the state was DRAW on the previous cycle; otherwise vga_plot = 0.
REQ-026 vga_x, vga_y, vga_colour hold their last values when vga_plot = 0.
REQ-027 Width rule: coordinates pass through unmodified; no arithmetic is applied.

Reset
REQ-028 On reset_n = 0 at a clock edge: state = IDLE, grant = 0, dp_reset_n = 4'b0000, vga_x = 0, vga_y = 0, vga_colour = 0, vga_plot = 0, busy = 0, timeout = 0, watchdog = 0.
REQ-029 On reset, last_winner = 3, so drawer 0 has top priority after reset.
REQ-030 Reset asserted mid-DRAW aborts the draw immediately; no RELEASE cycle is produced.

Configuration
REQ-031 Macro ARROW_PLOT_ARB_WDOG_EN.
REQ-032 With ARROW_PLOT_ARB_WDOG_EN defined: a 23-bit counter clears on entry to DRAW and increments each DRAW cycle.
REQ-033 With ARROW_PLOT_ARB_WDOG_EN defined: when the counter reaches WDOG_LIMIT without done, timeout pulses for 1 cycle and the state goes to RELEASE.
REQ-034 With ARROW_PLOT_ARB_WDOG_EN defined: if done and the limit occur in the same cycle, done wins and timeout stays 0.
REQ-035 Without ARROW_PLOT_ARB_WDOG_EN: no counter exists, timeout is tied to 0, and DRAW waits indefinitely for done.

Verification
REQ-036 Reset, then req = 4'b0001 -> GRANT next cycle with grant = 0001 and dp_reset_n = 0001; DRAW follows; busy = 1.
REQ-037 req = 4'b1111 held, each drawer asserts done 5 cycles into DRAW -> grant order 0001, 0010, 0100, 1000, 0001; grant = 0 for at least 2 cycles between grants.
REQ-038 Winner 2 drives x = 79, y = 63, colour = 3'b010, plot = 1 in DRAW -> next cycle vga_x = 79, vga_y = 63, vga_colour = 010, vga_plot = 1; plot from drawer 1 at the same time produces no write.
REQ-039 drw_done of drawer 0 and req of drawer 1 both rise during drawer 0's DRAW -> RELEASE, IDLE, then grant = 0010.
REQ-040 WDOG_EN defined, WDOG_LIMIT = 20, done never asserted -> timeout pulse after 20 DRAW cycles, then RELEASE; repeat with done in cycle 20 -> no timeout.
REQ-041 reset_n = 0 in mid-DRAW -> next edge: grant = 0, dp_reset_n = 0, vga_plot = 0, state = IDLE; after reset, req = 4'b1100 -> grant = 0100.

Source files
------------

// File: rtl/arrow_plot_arbiter.sv
// Round-robin arbiter that multiplexes four shape drawers onto one VGA adapter write port.
// Optional draw watchdog enabled by defining ARROW_PLOT_ARB_WDOG_EN.
module arrow_plot_arbiter #(
    parameter logic [22:0] WDOG_LIMIT = 23'd4000000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  req,
    input  logic [31:0] drw_x,
    input  logic [27:0] drw_y,
    input  logic [11:0] drw_colour,
    input  logic [3:0]  drw_plot,
    input  logic [3:0]  drw_done,
    output logic [3:0]  grant,
    output logic [3:0]  dp_reset_n,
    output logic [7:0]  vga_x,
    output logic [6:0]  vga_y,
    output logic [2:0]  vga_colour,
    output logic        vga_plot,
    output logic        busy,
    output logic        timeout
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_DRAW    = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    state_t      state_r;
    state_t      next_state_s;
    logic [1:0]  winner_r;
    logic [1:0]  winner_nx_s;
    logic [1:0]  last_winner_r;
    logic [3:0]  grant_r;
    logic [3:0]  grant_nx_s;
    logic [3:0]  dp_reset_n_r;
    logic        busy_r;
    logic        busy_nx_s;
    logic        timeout_r;
    logic        timeout_nx_s;
    logic [7:0]  vga_x_r;
    logic [6:0]  vga_y_r;
    logic [2:0]  vga_colour_r;
    logic        vga_plot_r;
    logic [7:0]  win_x_s;
    logic [6:0]  win_y_s;
    logic [2:0]  win_colour_s;
    logic        win_plot_s;
    logic        win_done_s;
    logic        plot_s;
    logic        wdog_hit_s;

    // First requester at or after last_v+1, wrapping modulo 4.
    function automatic logic [1:0] rr_pick(input logic [3:0] req_v, input logic [1:0] last_v);
        logic [1:0] idx_v;
        logic [1:0] pick_v;
        logic       found_v;
        found_v = 1'b0;
        pick_v  = last_v;
        for (int k = 1; k <= 4; k++) begin
            idx_v = last_v + 2'(k);
            if (!found_v && req_v[idx_v]) begin
                pick_v  = idx_v;
                found_v = 1'b1;
            end else begin
                pick_v  = pick_v;
            end
        end
        return pick_v;
    endfunction

    // Select the current winner's drawer signals.
    always_comb begin
        win_x_s      = 8'd0;
        win_y_s      = 7'd0;
        win_colour_s = 3'd0;
        win_plot_s   = 1'b0;
        win_done_s   = 1'b0;
        case (winner_r)
            2'd0: begin
                win_x_s      = drw_x[7:0];
                win_y_s      = drw_y[6:0];
                win_colour_s = drw_colour[2:0];
                win_plot_s   = drw_plot[0];
                win_done_s   = drw_done[0];
            end
            2'd1: begin
                win_x_s      = drw_x[15:8];
                win_y_s      = drw_y[13:7];
                win_colour_s = drw_colour[5:3];
                win_plot_s   = drw_plot[1];
                win_done_s   = drw_done[1];
            end
            2'd2: begin
                win_x_s      = drw_x[23:16];
                win_y_s      = drw_y[20:14];
                win_colour_s = drw_colour[8:6];
                win_plot_s   = drw_plot[2];
                win_done_s   = drw_done[2];
            end
            2'd3: begin
                win_x_s      = drw_x[31:24];
                win_y_s      = drw_y[27:21];
                win_colour_s = drw_colour[11:9];
                win_plot_s   = drw_plot[3];
                win_done_s   = drw_done[3];
            end
            default: begin
                win_x_s      = 8'd0;
                win_y_s      = 7'd0;
                win_colour_s = 3'd0;
                win_plot_s   = 1'b0;
                win_done_s   = 1'b0;
            end
        endcase
    end

`ifdef ARROW_PLOT_ARB_WDOG_EN
    logic [22:0] wdog_r;

    // Draw-cycle counter: cleared while in GRANT so the first DRAW cycle counts from zero.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wdog_r <= 23'd0;
        end else if (state_r == ST_GRANT) begin
            wdog_r <= 23'd0;
        end else if (state_r == ST_DRAW) begin
            wdog_r <= wdog_r + 23'd1;
        end else begin
            wdog_r <= wdog_r;
        end
    end

    assign wdog_hit_s = (state_r == ST_DRAW) && (wdog_r == (WDOG_LIMIT - 23'd1));
`else
    logic unused_wdog_limit_s;

    // WDOG_LIMIT has no effect without the watchdog.
    assign unused_wdog_limit_s = ^WDOG_LIMIT;
    assign wdog_hit_s          = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; done takes precedence over a simultaneous watchdog hit.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req != 4'b0000) begin
                    next_state_s = ST_GRANT;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_GRANT: begin
                next_state_s = ST_DRAW;
            end
            ST_DRAW: begin
                if (win_done_s || wdog_hit_s) begin
                    next_state_s = ST_RELEASE;
                end else begin
                    next_state_s = ST_DRAW;
                end
            end
            ST_RELEASE: begin
                next_state_s = ST_IDLE;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Output decode from the upcoming state so every output leaves a flop aligned with the state.
    always_comb begin
        winner_nx_s  = winner_r;
        grant_nx_s   = 4'b0000;
        busy_nx_s    = (next_state_s != ST_IDLE);
        timeout_nx_s = (state_r == ST_DRAW) && !win_done_s && wdog_hit_s;
        if ((state_r == ST_IDLE) && (req != 4'b0000)) begin
            winner_nx_s = rr_pick(req, last_winner_r);
        end else begin
            winner_nx_s = winner_r;
        end
        case (next_state_s)
            ST_GRANT, ST_DRAW: grant_nx_s = 4'b0001 << winner_nx_s;
            default:           grant_nx_s = 4'b0000;
        endcase
    end

    // Arbitration bookkeeping and registered control outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            winner_r      <= 2'd3;
            last_winner_r <= 2'd3;
            grant_r       <= 4'b0000;
            dp_reset_n_r  <= 4'b0000;
            busy_r        <= 1'b0;
            timeout_r     <= 1'b0;
        end else begin
            winner_r      <= winner_nx_s;
            last_winner_r <= (state_r == ST_RELEASE) ? winner_r : last_winner_r;
            grant_r       <= grant_nx_s;
            dp_reset_n_r  <= grant_nx_s;
            busy_r        <= busy_nx_s;
            timeout_r     <= timeout_nx_s;
        end
    end

    assign plot_s = (state_r == ST_DRAW) && win_plot_s;

    // VGA write port: coordinates and colour load only on a winner plot in DRAW.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            vga_x_r      <= 8'd0;
            vga_y_r      <= 7'd0;
            vga_colour_r <= 3'd0;
            vga_plot_r   <= 1'b0;
        end else begin
            vga_plot_r <= plot_s;
            if (plot_s) begin
                vga_x_r      <= win_x_s;
                vga_y_r      <= win_y_s;
                vga_colour_r <= win_colour_s;
            end else begin
                vga_x_r      <= vga_x_r;
                vga_y_r      <= vga_y_r;
                vga_colour_r <= vga_colour_r;
            end
        end
    end

    assign grant      = grant_r;
    assign dp_reset_n = dp_reset_n_r;
    assign busy       = busy_r;
    assign timeout    = timeout_r;
    assign vga_x      = vga_x_r;
    assign vga_y      = vga_y_r;
    assign vga_colour = vga_colour_r;
    assign vga_plot   = vga_plot_r;

endmodule

// File: tb/tb_arrow_plot_arbiter.sv
// Directed-vector bench for arrow_plot_arbiter; watchdog vectors run when ARROW_PLOT_ARB_WDOG_EN is defined.
module tb_arrow_plot_arbiter;

    logic        clk;
    logic        reset_n;
    logic [3:0]  req;
    logic [31:0] drw_x;
    logic [27:0] drw_y;
    logic [11:0] drw_colour;
    logic [3:0]  drw_plot;
    logic [3:0]  drw_done;
    logic [3:0]  grant;
    logic [3:0]  dp_reset_n;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [2:0]  vga_colour;
    logic        vga_plot;
    logic        busy;
    logic        timeout;

    int vec_cnt = 0;
    int err_cnt = 0;

    arrow_plot_arbiter #(.WDOG_LIMIT(23'd20)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req        (req),
        .drw_x      (drw_x),
        .drw_y      (drw_y),
        .drw_colour (drw_colour),
        .drw_plot   (drw_plot),
        .drw_done   (drw_done),
        .grant      (grant),
        .dp_reset_n (dp_reset_n),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot),
        .busy       (busy),
        .timeout    (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n  = 1'b0;
        req      = 4'b0000;
        drw_plot = 4'b0000;
        drw_done = 4'b0000;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    // Ticks until a grant appears (bounded); gap = number of zero-grant cycles seen.
    task automatic wait_grant(output int gap);
        gap = 0;
        while (grant == 4'b0000 && gap < 12) begin
            gap++;
            tick();
        end
        check_vec("grant_wait", {31'd0, grant != 4'b0000}, 32'd1);
    endtask

    initial begin
        int         gap;
        int         n;
        logic [3:0] exp_g;
        logic       seen_to;
        logic       held;

        reset_n    = 1'b0;
        req        = 4'b0000;
        drw_x      = 32'd0;
        drw_y      = 28'd0;
        drw_colour = 12'd0;
        drw_plot   = 4'b0000;
        drw_done   = 4'b0000;

        // Reset state.
        tick();
        tick();
        check_vec("rst_grant", {28'd0, grant}, 32'h0);
        check_vec("rst_dp", {28'd0, dp_reset_n}, 32'h0);
        check_vec("rst_vga", {13'd0, vga_x, vga_y, vga_colour, vga_plot}, 32'h0);
        check_vec("rst_busy", {30'd0, busy, timeout}, 32'h0);

        // Single request: GRANT, then DRAW; done in GRANT and req drop in DRAW are ignored.
        reset_n = 1'b1;
        req     = 4'b0001;
        tick();
        check_vec("g0_grant", {28'd0, grant}, 32'h1);
        check_vec("g0_dp", {28'd0, dp_reset_n}, 32'h1);
        check_vec("g0_busy", {31'd0, busy}, 32'h1);
        drw_done = 4'b0001;
        tick();
        check_vec("g0_done_in_grant", {28'd0, grant}, 32'h1);
        drw_done = 4'b0000;
        req      = 4'b0000;
        tick();
        check_vec("g0_req_drop", {28'd0, grant}, 32'h1);
        drw_done = 4'b1110;
        tick();
        check_vec("g0_other_done", {30'd0, busy, grant[0]}, 32'h3);
        drw_done = 4'b0001;
        tick();
        check_vec("g0_release", {24'd0, grant, dp_reset_n}, 32'h0);
        check_vec("g0_release_busy", {31'd0, busy}, 32'h1);
        drw_done = 4'b0000;
        tick();
        check_vec("g0_idle_busy", {31'd0, busy}, 32'h0);

        // Round-robin with all requesting, done 5 cycles into DRAW.
        do_reset();
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            exp_g = 4'b0001 << (k % 4);
            wait_grant(gap);
            check_vec($sformatf("rr_grant%0d", k), {28'd0, grant}, {28'd0, exp_g});
            if (k > 0) begin
                check_vec($sformatf("rr_gap%0d", k), {31'd0, gap >= 2}, 32'd1);
            end
            for (int c = 0; c < 5; c++) tick();
            check_vec($sformatf("rr_hold%0d", k), {28'd0, grant}, {28'd0, exp_g});
            drw_done = exp_g;
            tick();
            drw_done = 4'b0000;
        end
        req = 4'b0000;

        // Winner 2 datapath mux; plots outside DRAW or from other drawers are dropped.
        do_reset();
        drw_x      = {8'd0, 8'd11, 8'd5, 8'd0};
        drw_y      = {7'd0, 7'd9, 7'd6, 7'd0};
        drw_colour = {3'd0, 3'b111, 3'b101, 3'd0};
        req        = 4'b0100;
        tick();
        check_vec("w2_grant", {28'd0, grant}, 32'h4);
        drw_plot = 4'b0100;
        tick();
        check_vec("w2_plot_in_grant", {23'd0, vga_x, vga_plot}, 32'h0);
        drw_x      = {8'd0, 8'd79, 8'd5, 8'd0};
        drw_y      = {7'd0, 7'd63, 7'd6, 7'd0};
        drw_colour = {3'd0, 3'b010, 3'b101, 3'd0};
        drw_plot   = 4'b0110;
        tick();
        check_vec("w2_vga", {13'd0, vga_x, vga_y, vga_colour, vga_plot}, {13'd0, 8'd79, 7'd63, 3'b010, 1'b1});
        drw_plot = 4'b0010;
        tick();
        check_vec("w2_other_plot", {13'd0, vga_x, vga_y, vga_colour, vga_plot}, {13'd0, 8'd79, 7'd63, 3'b010, 1'b0});
        drw_plot = 4'b0000;
        drw_done = 4'b0100;
        req      = 4'b0000;
        tick();
        drw_done = 4'b0000;

        // Done of drawer 0 and req of drawer 1 together -> RELEASE, IDLE, then drawer 1.
        do_reset();
        req = 4'b0001;
        tick();
        tick();
        drw_done = 4'b0001;
        req      = 4'b0011;
        tick();
        check_vec("hand_release", {28'd0, grant}, 32'h0);
        drw_done = 4'b0000;
        tick();
        check_vec("hand_idle", {27'd0, busy, grant}, 32'h0);
        tick();
        check_vec("hand_grant1", {28'd0, grant}, 32'h2);

        // Long draw without done.
        do_reset();
        req = 4'b0001;
        tick();
        check_vec("wd_grant", {28'd0, grant}, 32'h1);
        n       = 0;
        seen_to = 1'b0;
        while (n < 40 && !seen_to) begin
            tick();
            n++;
            seen_to = timeout;
        end
`ifdef ARROW_PLOT_ARB_WDOG_EN
        check_vec("wd_cycles", n, 32'd21);
        check_vec("wd_release", {28'd0, grant}, 32'h0);
        tick();
        check_vec("wd_pulse_len", {31'd0, timeout}, 32'h0);
        wait_grant(gap);
        for (int c = 0; c < 20; c++) tick();
        check_vec("wd_cycle20_held", {28'd0, grant}, 32'h1);
        drw_done = 4'b0001;
        tick();
        check_vec("wd_done_wins", {27'd0, timeout, grant}, 32'h0);
        drw_done = 4'b0000;
`else
        held = (grant == 4'b0001);
        check_vec("nowd_no_timeout", {31'd0, seen_to}, 32'h0);
        check_vec("nowd_held", {31'd0, held}, 32'h1);
`endif

        // Reset mid-DRAW aborts immediately.
        do_reset();
        drw_x    = {8'd0, 8'd0, 8'd0, 8'd33};
        req      = 4'b0001;
        tick();
        tick();
        drw_plot = 4'b0001;
        tick();
        check_vec("abort_pre_plot", {31'd0, vga_plot}, 32'h1);
        reset_n = 1'b0;
        tick();
        check_vec("abort_outputs", {23'd0, grant, dp_reset_n, vga_plot}, 32'h0);
        check_vec("abort_idle", {31'd0, busy}, 32'h0);
        reset_n  = 1'b1;
        drw_plot = 4'b0000;
        req      = 4'b1100;
        tick();
        check_vec("abort_regrant", {28'd0, grant}, 32'h4);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
